jtag_host_driver: RTL and testbench
===================================

Name: jtag_host_driver

Overview:
- JTAG initiator that sequences a target TAP (boundary scan register, IR, bypass) from the system side.
- Accepts scan commands over a valid/ready interface and generates TCK, TMS and TDI from the system clock.
- Captures TDO during each shift and returns the captured bits as a response.
- Used as the on-chip or bench-side driver for the boundary-scan chain.

Parameters:
- MAX_LEN, 32, maximum scan length in bits (cmd_data/rsp_data width).
- TCK_DIV, 2, TCK half-period in clk cycles; must be >= 1.
- LEN_W, $clog2(MAX_LEN+1), width of cmd_len.

Ports:
- clk  input  1  system clock.
- TRST  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  driver can accept a command.
- cmd_type  input  2  00 DR scan, 01 IR scan, 10 TAP reset, 11 idle clocks.
- cmd_len  input  LEN_W  scan length in bits, or TCK count for idle.
- cmd_data  input  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_data  output  MAX_LEN  captured TDO bits, bit i = TDO during shift of bit i; bits >= len are zero.
- tck_o  output  1  JTAG TCK.
- tms_o  output  1  JTAG TMS.
- tdi_o  output  1  JTAG TDI.
- tdo_i  input  1  JTAG TDO from target.

Behaviour:
- Reset (TRST low, any time, async):
  - tck_o=0, tms_o=1, tdi_o=0, cmd_ready=1, rsp_valid=0, rsp_data=0.
  - FSM returns to IDLE and the TCK divider clears.
  - The target TAP state is assumed to be Run-Test/Idle after the first completed TAP-reset command.
- TCK generation:
  - One TCK period = 2*TCK_DIV clk cycles, low phase first.
  - tck_o idles low between commands.
  - tms_o and tdi_o update at the clk edge that drives tck_o low (the fall), or at command start.
  - tdo_i is sampled at the clk edge that drives tck_o high.
- Command acceptance:
  - Accept on cmd_valid && cmd_ready; latch type, len and data.
  - cmd_ready deasserts the next cycle and stays low until the response handshake completes.
- Length rules:
  - DR/IR with cmd_len=0 is treated as 1; cmd_len>MAX_LEN is clamped to MAX_LEN.
  - Idle with cmd_len=0 produces no TCK; rsp_valid asserts the cycle after acceptance.
- TMS sequences (one value per TCK, starting from Run-Test/Idle):
  - DR: header 1,0,0; then len shift bits with TMS=0 except the last, which is 1; then trailer 1,0. Total len+5 TCKs.
  - IR: header 1,1,0,0; shift as for DR; trailer 1,0. Total len+6 TCKs.
  - Reset: 1,1,1,1,1,0. Total 6 TCKs; tdi_o=0.
  - Idle: len TCKs with TMS=0, tdi_o=0.
- TDI/TDO during scans:
  - tdi_o = cmd_data[i] during shift bit i; tdi_o=0 outside shift bits.
  - TDO is captured only on the rising edges of shift bits.
- FSM states and transitions:
  - IDLE -> HDR on accept.
  - HDR -> SHIFT once the header count is exhausted.
  - SHIFT -> TRL after the last bit.
  - TRL -> RSP.
  - Reset and idle commands use HDR or SHIFT only, then go to RSP.
- Response:
  - RSP holds rsp_valid=1 with stable rsp_data until rsp_ready; then IDLE, and cmd_ready=1 the next cycle.
  - rsp_valid && rsp_ready in the same cycle that rsp_valid first rises completes in 1 cycle.
- Counters:
  - A bit counter of LEN_W bits and a header/trailer counter of 3 bits; neither wraps past its terminal value.
- Driver-side visibility of the target:
  - cmd_valid changes while busy are ignored.
  - TDO X/Z is captured as-is; no checking is done.

Decomposition:
- Package jtag_host_pkg:
  - cmd_type_t enum (CMD_DR, CMD_IR, CMD_RST, CMD_IDLE).
  - host_state_t enum (IDLE, HDR, SHIFT, TRL, RSP).
  - Header/trailer TMS constant vectors and lengths: DR_HDR=3'b001 with len 3, IR_HDR=4'b0011 with len 4, TRL=2'b01, RST=6'b011111; all LSB first.
- Sub-module jtag_tck_gen: TCK_DIV divider with enable, producing tck_o plus single-cycle tck_rise/tck_fall strobes.

Test Plan:
- Reset: hold TRST low -> tck_o=0, tms_o=1, cmd_ready=1, rsp_valid=0. Issue the reset command -> TMS 1,1,1,1,1,0 over 6 TCKs, then rsp_valid with rsp_data=0.
- DR scan, len=14 (9 in + 5 out boundary chain), cmd_data=0x2A5B, TAP+BSR model preloaded with capture 0x1234 -> TMS 1,0,0, 13x0, 1, 1,0 (19 TCKs); model receives 0x2A5B; rsp_data=0x1234.
- IR scan, len=4, data=0xA, model IR capture 0x1 -> 10 TCKs; header 1,1,0,0; TDI bits 0,1,0,1; rsp_data=0x1.
- TCK_DIV=1 and MAX_LEN scan (len=32, data=0xFFFFFFFF, TDO tied 0) -> TCK toggles every clk; 37 TCKs; rsp_data=0. Repeat with len=0 -> 1-bit scan.
- Back-pressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, a new cmd_valid is ignored. Release -> cmd_ready=1 the next cycle.
- TRST asserted mid-SHIFT at bit 5 of 14 -> same cycle: tck_o=0, tms_o=1, no rsp_valid. After release, a reset command followed by a DR scan completes correctly.

Source files
------------

// File: rtl/jtag_host_pkg.sv
// jtag_host_pkg: shared types and TMS constants for the JTAG host driver.
//   cmd_type_t   : command opcode carried on cmd_type
//   host_state_t : driver sequencing states
//   *_HDR/TRL/RST: TMS bit patterns, LSB is the first TCK
package jtag_host_pkg;

  typedef enum logic [1:0] {
    CMD_DR   = 2'b00,
    CMD_IR   = 2'b01,
    CMD_RST  = 2'b10,
    CMD_IDLE = 2'b11
  } cmd_type_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SHIFT,
    TRL,
    RSP
  } host_state_t;

  localparam logic [2:0] DR_HDR     = 3'b001;
  localparam int         DR_HDR_LEN = 3;
  localparam logic [3:0] IR_HDR     = 4'b0011;
  localparam int         IR_HDR_LEN = 4;
  localparam logic [1:0] TRL_TMS    = 2'b01;
  localparam int         TRL_LEN    = 2;
  localparam logic [5:0] RST_TMS    = 6'b011111;
  localparam int         RST_LEN    = 6;

  // Patterns are widened to 8 bits so a 3-bit counter indexes them cleanly.
  function automatic logic hdr_tms(cmd_type_t t, logic [2:0] idx);
    logic [7:0] v;
    case (t)
      CMD_IR:  v = 8'(IR_HDR);
      CMD_RST: v = 8'(RST_TMS);
      default: v = 8'(DR_HDR);
    endcase
    return v[idx];
  endfunction

  function automatic logic [2:0] hdr_last(cmd_type_t t);
    case (t)
      CMD_IR:  return 3'(IR_HDR_LEN - 1);
      CMD_RST: return 3'(RST_LEN - 1);
      default: return 3'(DR_HDR_LEN - 1);
    endcase
  endfunction

  function automatic logic trl_tms(logic [2:0] idx);
    logic [7:0] v;
    v = 8'(TRL_TMS);
    return v[idx];
  endfunction

endpackage

// File: rtl/jtag_host_driver_tck_gen.sv
// jtag_tck_gen: TCK divider. While en is high, TCK runs with a period of
// 2*TCK_DIV clk cycles, low phase first; while en is low TCK sits low.
//   clk, TRST    : system clock, async active-low reset
//   en           : run TCK
//   tck_o        : generated TCK
//   tck_rise     : high in the cycle whose closing clk edge raises tck_o
//   tck_fall     : high in the cycle whose closing clk edge lowers tck_o
module jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic TRST,
  input  logic en,
  output logic tck_o,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int            CW     = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TCK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tck_rise = en && (cnt == '0) && !tck_o;
  assign tck_fall = en && (cnt == '0) && tck_o;

  // Down-counter per half period; the idle value is the reload so the first
  // low phase after enable is a full TCK_DIV cycles.
  always_ff @(posedge clk or negedge TRST) begin
    if (!TRST) begin
      tck_o <= 1'b0;
      cnt   <= RELOAD;
    end else if (!en) begin
      tck_o <= 1'b0;
      cnt   <= RELOAD;
    end else if (cnt == '0) begin
      tck_o <= ~tck_o;
      cnt   <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/jtag_host_driver.sv
// jtag_host_driver: JTAG initiator. Takes DR/IR scan, TAP reset and idle
// commands over valid/ready, drives TCK/TMS/TDI and returns captured TDO.
//   clk, TRST                          : system clock, async active-low reset
//   cmd_valid/ready/type/len/data      : command channel
//   rsp_valid/ready/data               : response channel (captured TDO)
//   tck_o, tms_o, tdi_o, tdo_i         : JTAG pins
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// HDR   | TMS header walking the TAP into Shift-DR/IR, or the reset pattern
// SHIFT | shift bits (or idle clocks); TDO captured on shift-bit rises
// TRL   | TMS trailer back to Run-Test/Idle
// RSP   | rsp_valid held until rsp_ready
module jtag_host_driver
  import jtag_host_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int TCK_DIV = 2,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  host_state_t        state;
  cmd_type_t          ctype;
  logic [LEN_W-1:0]   last_idx;
  logic [LEN_W-1:0]   bidx;
  logic [LEN_W-1:0]   bidx_inc;
  logic [LEN_W-1:0]   scan_last;
  logic [2:0]         hcnt;
  logic [MAX_LEN-1:0] data_q;
  logic               tck_en;
  logic               tck_rise;
  logic               tck_fall;

  assign tck_en   = (state == HDR) || (state == SHIFT) || (state == TRL);
  assign bidx_inc = bidx + 1'b1;

  // Scan length 0 behaves as 1, anything above MAX_LEN is clamped.
  always_comb begin
    if (cmd_len == '0)
      scan_last = '0;
    else if (cmd_len > LEN_W'(MAX_LEN))
      scan_last = LEN_W'(MAX_LEN - 1);
    else
      scan_last = cmd_len - 1'b1;
  end

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk      (clk),
    .TRST     (TRST),
    .en       (tck_en),
    .tck_o    (tck_o),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  // TMS/TDI for the next TCK are loaded on the fall that ends the current one.
  always_ff @(posedge clk or negedge TRST) begin
    if (!TRST) begin
      state     <= IDLE;
      ctype     <= CMD_DR;
      last_idx  <= '0;
      bidx      <= '0;
      hcnt      <= '0;
      data_q    <= '0;
      rsp_data  <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      tms_o     <= 1'b1;
      tdi_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          cmd_ready <= 1'b0;
          ctype     <= cmd_type_t'(cmd_type);
          data_q    <= cmd_data;
          rsp_data  <= '0;
          hcnt      <= '0;
          bidx      <= '0;
          tdi_o     <= 1'b0;
          if (cmd_type == CMD_IDLE) begin
            last_idx <= cmd_len - 1'b1;
            tms_o    <= 1'b0;
            if (cmd_len == '0) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end else begin
            last_idx <= scan_last;
            tms_o    <= 1'b1;
            state    <= HDR;
          end
        end
        HDR: if (tck_fall) begin
          if (hcnt == hdr_last(ctype)) begin
            hcnt <= '0;
            if (ctype == CMD_RST) begin
              state     <= RSP;
              rsp_valid <= 1'b1;
            end else begin
              state <= SHIFT;
              tms_o <= (last_idx == '0);
              tdi_o <= data_q[0];
            end
          end else begin
            hcnt  <= hcnt + 1'b1;
            tms_o <= hdr_tms(ctype, hcnt + 1'b1);
          end
        end
        SHIFT: begin
          if (tck_rise && (ctype != CMD_IDLE))
            rsp_data[bidx[IW-1:0]] <= tdo_i;
          if (tck_fall) begin
            if (bidx == last_idx) begin
              tdi_o <= 1'b0;
              if (ctype == CMD_IDLE) begin
                state     <= RSP;
                rsp_valid <= 1'b1;
              end else begin
                state <= TRL;
                hcnt  <= '0;
                tms_o <= trl_tms(3'd0);
              end
            end else begin
              bidx  <= bidx_inc;
              tms_o <= (ctype != CMD_IDLE) && (bidx_inc == last_idx);
              tdi_o <= (ctype != CMD_IDLE) && data_q[bidx_inc[IW-1:0]];
            end
          end
        end
        TRL: if (tck_fall) begin
          if (hcnt == 3'(TRL_LEN - 1)) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
          end else begin
            hcnt  <= hcnt + 1'b1;
            tms_o <= trl_tms(hcnt + 1'b1);
          end
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_host_driver.sv
// tb_jtag_host_driver: directed bench for jtag_host_driver. A TAP model with
// a 4-bit IR and a variable-length DR sits on the TCK_DIV=2 instance; a
// second TCK_DIV=1 instance with TDO tied low checks the fast divider and
// length clamping.
module tb_jtag_host_driver;
  import jtag_host_pkg::*;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic clk = 1'b0;
  logic TRST = 1'b0;
  always #5 clk = ~clk;

  logic               cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
  logic [1:0]         cmd_type = 2'b00;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0, rsp_data;
  logic               tck0, tms0, tdi0;
  logic               tdo_q = 1'b0;

  logic               cmd_valid1 = 1'b0, cmd_ready1, rsp_valid1, rsp_ready1 = 1'b0;
  logic [1:0]         cmd_type1 = 2'b00;
  logic [LEN_W-1:0]   cmd_len1 = '0;
  logic [MAX_LEN-1:0] cmd_data1 = '0, rsp_data1;
  logic               tck1, tms1, tdi1;

  jtag_host_driver #(.MAX_LEN(MAX_LEN), .TCK_DIV(2)) u_dut (
    .clk(clk), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tck_o(tck0), .tms_o(tms0), .tdi_o(tdi0), .tdo_i(tdo_q)
  );

  jtag_host_driver #(.MAX_LEN(MAX_LEN), .TCK_DIV(1)) u_dut1 (
    .clk(clk), .TRST(TRST), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_type(cmd_type1), .cmd_len(cmd_len1), .cmd_data(cmd_data1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
    .tck_o(tck1), .tms_o(tms1), .tdi_o(tdi1), .tdo_i(1'b0)
  );

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPIR
  } tap_t;

  tap_t        tap = TLR;
  logic [31:0] dr_sr = '0, dr_rx = '0, dr_cap = '0;
  logic [3:0]  ir_sr = '0, ir_rx = '0, ir_cap = '0;
  int          dr_len = 1;

  function automatic tap_t next_tap(tap_t s, logic m);
    case (s)
      TLR:         return m ? TLR   : RTI;
      RTI:         return m ? SELDR : RTI;
      SELDR:       return m ? SELIR : CAPDR;
      CAPDR, SHDR: return m ? EX1DR : SHDR;
      EX1DR:       return m ? UPDR  : PSDR;
      PSDR:        return m ? EX2DR : PSDR;
      EX2DR:       return m ? UPDR  : SHDR;
      UPDR, UPIR:  return m ? SELDR : RTI;
      SELIR:       return m ? TLR   : CAPIR;
      CAPIR, SHIR: return m ? EX1IR : SHIR;
      EX1IR:       return m ? UPIR  : PSIR;
      PSIR:        return m ? EX2IR : PSIR;
      EX2IR:       return m ? UPIR  : SHIR;
      default:     return TLR;
    endcase
  endfunction

  always @(posedge tck0) begin
    case (tap)
      CAPDR:   dr_sr <= dr_cap;
      SHDR:    dr_sr <= (dr_sr >> 1) | (32'(tdi0) << (dr_len - 1));
      UPDR:    dr_rx <= dr_sr;
      CAPIR:   ir_sr <= ir_cap;
      SHIR:    ir_sr <= {tdi0, ir_sr[3:1]};
      UPIR:    ir_rx <= ir_sr;
      default: ;
    endcase
    tap <= next_tap(tap, tms0);
  end

  always @(negedge tck0)
    tdo_q <= (tap == SHDR) ? dr_sr[0] : (tap == SHIR) ? ir_sr[0] : 1'b0;

  // Per-TCK history of TMS/TDI as seen by the target at each rise.
  bit tms_hist [0:4095];
  bit tdi_hist [0:4095];
  int tck_total = 0;
  int tck1_total = 0;

  always @(posedge tck0) begin
    if (tck_total < 4096) begin
      tms_hist[tck_total] <= tms0;
      tdi_hist[tck_total] <= tdi0;
    end
    tck_total <= tck_total + 1;
  end

  always @(posedge tck1) tck1_total <= tck1_total + 1;

  // ---------------- checking ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [1:0]  typ;
    logic [5:0]  len;
    logic [31:0] data;
    logic [31:0] cap;
    int          dlen;
    int          tcks;
    logic [63:0] tms;
    logic [63:0] tdi;
    logic [31:0] rsp;
    logic [31:0] rx;
    int          chk;   // 0 none, 1 DR received, 2 IR received
  } vec_t;

  function automatic vec_t mk(logic [1:0] t, logic [5:0] l, logic [31:0] d, logic [31:0] c,
                              int dl, int tk, logic [63:0] tm, logic [63:0] ti,
                              logic [31:0] r, logic [31:0] x, int ch);
    vec_t v;
    v.typ = t; v.len = l; v.data = d; v.cap = c; v.dlen = dl; v.tcks = tk;
    v.tms = tm; v.tdi = ti; v.rsp = r; v.rx = x; v.chk = ch;
    return v;
  endfunction

  vec_t vecs [8];

  task automatic run_vec(input vec_t v, input int id);
    int start, lat, n;
    bit ok;
    logic [63:0] tms_a, tdi_a;
    logic [31:0] rsp_a;
    dr_cap = v.cap; ir_cap = v.cap[3:0]; dr_len = v.dlen;
    start = tck_total;
    check($sformatf("v%0d_ready", id), 64'(cmd_ready), 64'd1);
    cmd_type = v.typ; cmd_len = v.len; cmd_data = v.data; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    ok = 1'b0; lat = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rsp_valid) begin ok = 1'b1; lat = i; break; end
      @(negedge clk);
    end
    check($sformatf("v%0d_done", id), 64'(ok), 64'd1);
    rsp_a = rsp_data;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("v%0d_release", id), {62'd0, cmd_ready, rsp_valid}, 64'b10);
    n = tck_total - start;
    tms_a = '0; tdi_a = '0;
    for (int k = 0; k < n && k < 64; k++) begin
      tms_a[k] = tms_hist[start + k];
      tdi_a[k] = tdi_hist[start + k];
    end
    check($sformatf("v%0d_latency", id), 64'(lat), 64'(4 * v.tcks));
    check($sformatf("v%0d_tcks", id), 64'(n), 64'(v.tcks));
    check($sformatf("v%0d_tms", id), tms_a, v.tms);
    check($sformatf("v%0d_tdi", id), tdi_a, v.tdi);
    check($sformatf("v%0d_rsp", id), 64'(rsp_a), 64'(v.rsp));
    if (v.chk == 1) check($sformatf("v%0d_dr_rx", id), 64'(dr_rx), 64'(v.rx));
    if (v.chk == 2) check($sformatf("v%0d_ir_rx", id), 64'(ir_rx), 64'(v.rx));
    check($sformatf("v%0d_tap_rti", id), 64'(tap), 64'(RTI));
  endtask

  task automatic run1(input logic [5:0] len, input int exp_rises, input string nm);
    int start, bad;
    bit ok;
    logic prev;
    check({nm, "_ready"}, 64'(cmd_ready1), 64'd1);
    start = tck1_total;
    cmd_type1 = CMD_DR; cmd_len1 = len; cmd_data1 = 32'hFFFF_FFFF; cmd_valid1 = 1'b1;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    prev = tck1; bad = 0; ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rsp_valid1) begin ok = 1'b1; break; end
      if (tck1 == prev) bad++;
      prev = tck1;
    end
    check({nm, "_done"}, 64'(ok), 64'd1);
    check({nm, "_toggle"}, 64'(bad), 64'd0);
    check({nm, "_rises"}, 64'(tck1_total - start), 64'(exp_rises));
    check({nm, "_rsp"}, 64'(rsp_data1), 64'd0);
    rsp_ready1 = 1'b1;
    @(negedge clk);
    rsp_ready1 = 1'b0;
  endtask

  initial begin
    int start, bad_hold;
    bit ok;

    vecs[0] = mk(CMD_RST,  6'd0,  32'hFFFF, 32'h0,    1,  6, 64'h1F,    64'h0,     32'h0,    32'h0,    0);
    vecs[1] = mk(CMD_DR,   6'd14, 32'h2A5B, 32'h1234, 14, 19, 64'h30001, 64'h152D8, 32'h1234, 32'h2A5B, 1);
    vecs[2] = mk(CMD_IR,   6'd4,  32'hA,    32'h1,    4,  10, 64'h183,   64'hA0,    32'h1,    32'hA,    2);
    vecs[3] = mk(CMD_IDLE, 6'd3,  32'hF,    32'h0,    1,  3,  64'h0,     64'h0,     32'h0,    32'h0,    0);
    vecs[4] = mk(CMD_DR,   6'd0,  32'h3,    32'h1,    1,  6,  64'h19,    64'h8,     32'h1,    32'h1,    1);
    vecs[5] = mk(CMD_DR,   6'd8,  32'hC3,   32'h5A,   8,  13, 64'hC01,   64'h618,   32'h5A,   32'hC3,   1);
    vecs[6] = mk(CMD_DR,   6'd8,  32'h1C3,  32'hA5,   8,  13, 64'hC01,   64'h618,   32'hA5,   32'hC3,   1);
    vecs[7] = mk(CMD_IDLE, 6'd0,  32'hF,    32'h0,    1,  0,  64'h0,     64'h0,     32'h0,    32'h0,    0);

    // Reset state while TRST is held low.
    repeat (3) @(negedge clk);
    check("rst_pins", {60'd0, tck0, tms0, tdi0, 1'b0}, 64'b0100);
    check("rst_hs", {62'd0, cmd_ready, rsp_valid}, 64'b10);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_dut1", {59'd0, tck1, tms1, tdi1, cmd_ready1, rsp_valid1}, 64'b01010);
    TRST = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) run_vec(vecs[v], v);

    // Back-pressure: response held, a new command must be ignored.
    dr_cap = 32'h5A; dr_len = 8;
    cmd_type = CMD_DR; cmd_len = 6'd8; cmd_data = 32'hC3; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("bp_done", 64'(ok), 64'd1);
    start = tck_total;
    bad_hold = 0;
    cmd_type = CMD_IR; cmd_len = 6'd4; cmd_data = 32'h5; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(rsp_valid && !cmd_ready && rsp_data == 32'h5A)) bad_hold++;
      @(negedge clk);
    end
    check("bp_hold", 64'(bad_hold), 64'd0);
    check("bp_no_tck", 64'(tck_total - start), 64'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_release", {62'd0, cmd_ready, rsp_valid}, 64'b10);
    @(negedge clk);
    check("bp_stay_idle", {62'd0, cmd_ready, tck0}, 64'b10);

    // Fast divider, full-length, zero-length and over-length scans.
    run1(6'd32, 37, "div1_len32");
    run1(6'd0,  6,  "div1_len0");
    run1(6'd40, 37, "div1_len40");

    // TRST in the middle of shift bit 5 of a 14-bit DR scan.
    dr_cap = 32'h1234; dr_len = 14;
    start = tck_total;
    cmd_type = CMD_DR; cmd_len = 6'd14; cmd_data = 32'h2A5B; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tck_total - start >= 9) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("abort_reach_bit5", 64'(ok), 64'd1);
    check("abort_pre_tck", 64'(tck0), 64'd1);
    TRST = 1'b0;
    #1;
    check("abort_pins", {61'd0, tck0, tms0, tdi0}, 64'b010);
    check("abort_hs", {62'd0, cmd_ready, rsp_valid}, 64'b10);
    repeat (3) @(negedge clk);
    check("abort_no_rsp", 64'(rsp_valid), 64'd0);
    TRST = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(vecs[0], 10);
    run_vec(vecs[1], 11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
